// File: rtl/des_sbox_sequencer.sv
// Time-multiplexed DES substitution stage: eight 6-bit chunks pass through S1..S8,
// one lookup per clock, and the 4-bit results are assembled into a 32-bit value.
module des_sbox_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Each table holds entries 0..63 (row*16 + column) from the MSB downward.
    localparam logic [255:0] S1 = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    localparam logic [255:0] S2 = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    localparam logic [255:0] S3 = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    localparam logic [255:0] S4 = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    localparam logic [255:0] S5 = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    localparam logic [255:0] S6 = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    localparam logic [255:0] S7 = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    localparam logic [255:0] S8 = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

    state_t        state_q;
    logic [47:0]   in_reg_q;
    logic [2:0]    idx_q;
    logic [31:0]   acc_q, acc_d;
    logic          in_ready_q, out_valid_q, busy_q;

    logic [47:0]   in_sh;
    logic [5:0]    chunk;
    logic [5:0]    entry;
    logic [255:0]  tbl, tbl_sh;
    logic [3:0]    nib;
    logic [4:0]    sh;

    always_comb begin
        in_sh  = in_reg_q << (6 * idx_q);
        chunk  = in_sh[47:42];
        entry  = {chunk[5], chunk[0], chunk[4:1]};
        tbl    = '0;
        case (idx_q)
            3'd0: tbl = S1;
            3'd1: tbl = S2;
            3'd2: tbl = S3;
            3'd3: tbl = S4;
            3'd4: tbl = S5;
            3'd5: tbl = S6;
            3'd6: tbl = S7;
            3'd7: tbl = S8;
            default: tbl = '0;
        endcase
        tbl_sh = tbl << {entry, 2'b00};
        nib    = tbl_sh[255:252];
        // ~idx equals 7-idx, so this places S1 at [31:28] down to S8 at [3:0]
        sh     = {~idx_q, 2'b00};
        acc_d  = (acc_q & ~(32'hF << sh)) | ({28'h0, nib} << sh);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_reg_q    <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        in_reg_q   <= in_data;
                        acc_q      <= '0;
                        idx_q      <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_des_sbox_sequencer.sv
// Directed and random checks of des_sbox_sequencer against a decimal DES S-box model,
// with expected results queued at stimulus time and popped when out_valid appears.
module tb_des_sbox_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit toggle   = 1'b0;
    logic [31:0] sb[$];

    int SB [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    des_sbox_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [31:0] model(input logic [47:0] d);
        logic [31:0] r;
        logic [5:0]  ch;
        int          row, col;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            ch  = d[47 - 6*i -: 6];
            row = {ch[5], ch[0]};
            col = ch[4:1];
            r[31 - 4*i -: 4] = 4'(SB[i][row*16 + col]);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] rnd48();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[47:0];
    endfunction

    // Present one value and hold it until the accepting edge; returns the accept cycle.
    task automatic send(input logic [47:0] d, output int acc_cyc);
        int k;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_before_send", in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        sb.push_back(model(d));
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid, then pop and compare against the scoreboard.
    task automatic wait_out(input string tag, output int seen_cyc);
        logic [31:0] exp;
        bit ok;
        ok = 1'b0;
        seen_cyc = -1;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            if (toggle) begin
                in_data  = rnd48();
                in_valid = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        if (toggle) in_valid = 1'b0;
        if (!ok) begin
            chk({tag, "_timeout"}, out_valid, 1);
        end else begin
            seen_cyc = cyc;
            exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx;
            chk(tag, out_data, exp);
        end
    endtask

    initial begin
        int a0, t0, t1;
        logic [31:0] held;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_out_data", out_data, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // All-zero input and latency
        send(48'h0, a0);
        chk("in_ready_in_run", in_ready, 0);
        chk("busy_in_run", busy, 1);
        wait_out("zero_result", t0);
        chk("latency", t0 - a0, 8);
        @(negedge clk);
        chk("in_ready_after_accept", in_ready, 1);
        chk("out_valid_after_accept", out_valid, 0);

        // All-ones input, output held with out_ready low
        out_ready = 1'b0;
        send(48'hFFFFFFFFFFFF, a0);
        wait_out("ones_result", t0);
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_out_data", out_data, 32'hD9CE3DCB);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_busy", busy, 1);
        end
        chk("hold_stable", out_data, held);
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_out_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);

        // Back-to-back with in_valid tied high; data changes during RUN are ignored
        in_valid = 1'b1;
        in_data  = 48'h0;
        sb.push_back(model(48'h0));
        @(negedge clk);
        in_data  = 48'hFFFFFFFFFFFF;
        sb.push_back(model(48'hFFFFFFFFFFFF));
        wait_out("b2b_first", t0);
        @(negedge clk);
        chk("b2b_in_ready_idle", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out("b2b_second", t1);
        chk("b2b_spacing", t1 - t0, 10);
        @(negedge clk);

        // Reset during the 4th RUN cycle discards the partial result
        send(48'h123456789ABC, a0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrun_rst_in_ready", in_ready, 1);
        chk("midrun_rst_out_valid", out_valid, 0);
        chk("midrun_rst_out_data", out_data, 0);
        chk("midrun_rst_busy", busy, 0);
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        t0 = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) t0++;
        end
        chk("no_out_valid_after_rst", t0, 0);
        send(48'h0, a0);
        wait_out("post_rst_result", t0);
        chk("post_rst_latency", t0 - a0, 8);
        @(negedge clk);

        // Random sweep with inputs toggled during RUN
        toggle = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            send(rnd48(), a0);
            wait_out("random_result", t0);
            @(negedge clk);
        end
        toggle = 1'b0;
        chk("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/des_sbox_sequencer.md
# des_sbox_sequencer

Time-multiplexed DES substitution stage. It accepts one 48-bit expanded-and-key-mixed round value and passes its eight 6-bit chunks through the eight DES S-box lookups (S1..S8), one chunk per clock. It assembles the eight 4-bit results into the 32-bit pre-permutation (P) value and returns it over a valid/ready handshake. It sits between the key-XOR and the P-permutation in the iterative DES round datapath, and trades 8 cycles of latency for a single lookup path.

## Interface
Parameters:
- none

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a new value; high only in IDLE
- in_data  input  48  round value; bits [47:42] go to S1, [41:36] to S2, …, [5:0] to S8
- out_valid  output  1  out_data holds a completed result
- out_ready  input  1  consumer accepts out_data
- out_data  output  32  S1 result in [31:28], S2 in [27:24], …, S8 in [3:0]
- busy  output  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE.
- Internal registers:
  - in_reg (48 bits) holds the captured input.
  - idx (3 bits) is the S-box index.
  - acc (32 bits) is the result accumulator.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_data into in_reg, clear acc to 0, set idx=0, go to RUN.
- RUN:
  - Each cycle the chunk is in_reg[47-6*idx -: 6].
  - Row = {chunk[5], chunk[0]}; column = chunk[4:1]; lookup uses the standard DES table S(idx+1).
  - The 4-bit result is written to acc[31-4*idx -: 4] on the clock edge.
  - idx increments on each edge.
  - On the edge that writes idx=7: go to DONE. idx wraps to 0 and is not used again until the next capture.
  - The S-box mux is purely combinational from in_reg and idx, with no extra pipeline register.
- DONE:
  - out_valid=1; out_data=acc, held stable until accepted.
  - On out_ready: go to IDLE.
  - in_ready stays 0 in DONE, so no input is accepted in the same cycle as output acceptance.
- in_data, and in_valid outside IDLE, are ignored. A change to in_data during RUN does not affect the result.
- out_data is driven from acc in every state. It is meaningful only while out_valid=1.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - out_data=32'h0, idx=0, in_reg=0.
- Reset is asynchronous and takes effect immediately, including mid-RUN or in DONE. Any partial result is discarded and no out_valid pulse is produced.
- Latency, with the input accepted on edge E0:
  - RUN occupies the cycles after E0 through edge E8.
  - out_valid rises after E8: 8 cycles from acceptance to out_valid.
- Minimum throughput: one result per 10 cycles (accept, 8 RUN, 1 DONE with out_ready=1, then IDLE). in_ready returns 1 in the cycle after output acceptance.
- out_ready held low: DONE persists indefinitely with out_data unchanged. busy stays 1 and in_ready stays 0.
- in_valid asserted continuously: a new value is accepted in every IDLE cycle, i.e. the first cycle after each DONE.

## Test plan
- After reset, check in_ready=1 and out_valid=0. Send in_data=48'h000000000000 -> out_data=32'hEFA72C4D, with out_valid rising exactly 8 cycles after acceptance.
- Send in_data=48'hFFFFFFFFFFFF -> out_data=32'hD9CE3DCB.
- Hold out_ready=0 for 5 cycles after out_valid:
  - out_data stays stable and in_ready stays 0;
  - on out_ready=1, out_valid drops the next cycle and in_ready=1.
- Back-to-back transfers with in_valid and out_ready tied high, sending 48'h0 then 48'hFFFFFFFFFFFF -> results 32'hEFA72C4D then 32'hD9CE3DCB, 10 cycles apart.
- Assert rst for 1 cycle during the 4th RUN cycle -> immediate return to IDLE with out_data=0 and no out_valid. The next input, 48'h0, yields 32'hEFA72C4D.
- Random-vector sweep: 1000 random 48-bit inputs compared against a software DES S-box model, including inputs toggled during RUN (must not affect the result).
